fp16_serial_accum: RTL and testbench
====================================

// Module: fp16_serial_accum
// PURPOSE
// Serial accumulator around the combinational fp16 adder in the filter datapath.
// Takes a stream of fp16 terms (tap products) over a valid/ready handshake.
// Drives the adder with {running sum, incoming term} and registers the adder result.
// After NUM_TERMS accepted terms it presents the total downstream, then restarts from zero.
// PARAMETERS
// NUM_TERMS  8  terms summed per output result (>=1)
// CNT_W      4  counter width; must satisfy 2**CNT_W > NUM_TERMS
// PORTS
// clk        in   1   clock, all state on rising edge
// rst_n      in   1   asynchronous active-low reset
// clear      in   1   synchronous flush: drop partial sum, restart count
// in_valid   in   1   in_data carries a term
// in_ready   out  1   block accepts a term this cycle
// in_data    in   16  fp16 term
// add_a      out  16  to adder operand A (= running sum)
// add_b      out  16  to adder operand B (= in_data)
// add_sum    in   16  from adder result (combinational, same cycle)
// out_valid  out  1   out_data holds a finished total
// out_ready  in   1   downstream accepts the total
// out_data   out  16  fp16 total
// busy       out  1   high when cnt != 0 or state == OUT
// BEHAVIOUR
// - Reset (async, rst_n=0): state=ACC, acc=16'h0000, cnt=0, out_valid=0, out_data=16'h0000.
// - add_a = acc and add_b = in_data at all times. The adder is a pure function; no handshake on it.
// - in_ready = (state==ACC) && !clear.
// - ACC: on in_valid&&in_ready: acc<=add_sum, cnt<=cnt+1.
//   - If cnt==NUM_TERMS-1 on that accept: state<=OUT, out_data<=add_sum, out_valid<=1, cnt<=0.
// - OUT: out_valid=1 and out_data held stable until out_ready=1.
//   - On out_valid&&out_ready: out_valid<=0, acc<=0, state<=ACC.
//   - in_ready stays 0 during the handshake cycle; there is no bypass into the next sum.
// - Latency: out_valid rises the cycle after the NUM_TERMS-th accept. Peak throughput is 1 term/cycle.
// - Each total costs NUM_TERMS accept cycles plus at least 1 output cycle.
// - clear (sync, highest priority after reset):
//   - In ACC: acc<=0, cnt<=0. A simultaneous in_valid term is not accepted (in_ready=0).
//   - In OUT: pending total is discarded, out_valid<=0, acc<=0, state<=ACC.
// - Arithmetic: accumulation order is strictly arrival order.
//   - The first term of a sum passes through exactly (adder returns B when A==0).
//   - x + (-x) yields 16'h0000.
//   - No saturation or overflow flag: an out-of-range sum is whatever add_sum returns, registered as-is.
// - in_data is sampled only on accept. Data on non-accepted cycles has no effect.
// - Counter wraps only via the NUM_TERMS-1 compare; it never reaches NUM_TERMS.
// TESTING
// - NUM_TERMS=8; eight 16'h3C00 (1.0) back-to-back, out_ready=1 -> one out_valid pulse, out_data=16'h4800 (8.0), 9 cycles from first accept.
// - Terms 16'h4000,16'hC000 alternating x4 -> out_data=16'h0000; then 16'h4000,16'h3C00 + six 16'h0000 -> 16'h4200 (3.0).
// - Total ready, out_ready=0 for 5 cycles -> out_data/out_valid stable, in_ready=0; out_ready=1 -> handshake, in_ready=1 next cycle.
// - Three 16'h3C00 accepted, then clear with in_valid=1 -> that term not accepted, busy=0; next eight 1.0 -> 16'h4800.
// - rst_n low mid-sum (cnt=5) and while out_valid=1 -> outputs at reset values immediately; after release, eight 1.0 -> 16'h4800.
// - Random in_valid gaps (~50%) with eight 16'h3C00 -> identical total 16'h4800; no term lost or duplicated.

Source files
------------

// File: rtl/fp16_serial_accum.sv
// Serial fp16 accumulator: feeds {running sum, term} to an external combinational
// adder, registers the result, and presents the total after NUM_TERMS accepted terms.
module fp16_serial_accum #(
  parameter int NUM_TERMS = 8,
  parameter int CNT_W     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  input  logic [15:0] add_sum,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        busy
);

  typedef enum logic {ACC = 1'b0, OUT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [15:0]        acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_TERMS - 1);

  assign add_a     = acc_q;
  assign add_b     = in_data;
  assign in_ready  = (state_q == ACC) && !clear;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (cnt_q != '0) || (state_q == OUT);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (clear) begin
      // Flush wins over both accept and output handshake.
      state_d     = ACC;
      acc_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (in_valid) begin
            acc_d = add_sum;
            if (cnt_q == LAST) begin
              cnt_d       = '0;
              state_d     = OUT;
              out_data_d  = add_sum;
              out_valid_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            state_d     = ACC;
            acc_d       = '0;
            out_valid_d = 1'b0;
          end
        end
        default: state_d = ACC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_fp16_serial_accum.sv
// Bench for fp16_serial_accum: behavioural fp16 adder on the adder ports, expected
// totals queued when terms are sent and popped when the DUT presents a result.
module tb_fp16_serial_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic [15:0] add_sum;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [15:0] exp_q[$];

  fp16_serial_accum #(.NUM_TERMS(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic real fp16_to_real(input logic [15:0] h);
    real m;
    int  e;
    e = int'(h[14:10]);
    if (e == 0) begin
      m = real'(h[9:0]) / 1024.0;
      e = -14;
    end else begin
      m = 1.0 + real'(h[9:0]) / 1024.0;
      e = e - 15;
    end
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] real_to_fp16(input real r);
    logic s;
    int   e;
    int   f;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    if (s) r = -r;
    e = 15;
    while (r >= 2.0) begin r = r / 2.0; e++; end
    while (r < 1.0)  begin r = r * 2.0; e--; end
    f = int'((r - 1.0) * 1024.0);
    if (f >= 1024) begin f = 0; e++; end
    if (e >= 31) return {s, 15'h7C00};
    if (e <= 0)  return 16'h0000;
    return {s, e[4:0], f[9:0]};
  endfunction

  assign add_sum = real_to_fp16(fp16_to_real(add_a) + fp16_to_real(add_b));

  // Offers one term, optionally idling with junk data first; returns once accepted.
  task automatic push_term(input logic [15:0] d, input int gap_pct, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = d;
        if (in_ready) begin
          @(posedge clk);
          ok = 1'b1;
          return;
        end
      end
    end
  endtask

  task automatic send_terms(input logic [15:0] t[8], input int n, input int gap_pct);
    bit ok;
    for (int i = 0; i < n; i++) begin
      push_term(t[i], gap_pct, ok);
      n_cmp++;
      if (!ok) begin
        n_err++;
        $display("FAIL accept_timeout term %0d: got no accept, required accept", i);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 16'hDEAD;
  endtask

  // Waits (bounded) for out_valid, handshakes it, and returns the data seen.
  task automatic get_total(output bit ok, output logic [15:0] d);
    ok = 1'b0;
    d  = 16'hxxxx;
    for (int t = 0; t < 50; t++) begin
      if (out_valid) begin
        d = out_data;
        ok = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_total(input string name);
    bit ok;
    logic [15:0] d, e;
    get_total(ok, d);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: out_valid never rose, required total %h", name, e);
    end else if (d !== e) begin
      n_err++;
      $display("FAIL %s: out_data=%h required %h", name, d, e);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    n_cmp++;
    if ({out_valid, out_data, busy, in_ready, add_a} !== {1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000}) begin
      n_err++;
      $display("FAIL reset_state: ov=%b od=%h busy=%b ir=%b acc=%h required 0 0000 0 1 0000",
               out_valid, out_data, busy, in_ready, add_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back;
    int first, rise;
    first = 0; rise = -1;
    exp_q.push_back(16'h4800);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'h3C00;
      if (i == 0) first = cyc + 1;
      n_cmp++;
      if (!in_ready || out_valid) begin
        n_err++;
        $display("FAIL b2b_stream term %0d: in_ready=%b out_valid=%b required 1 0", i, in_ready, out_valid);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (out_valid) rise = cyc;
    n_cmp++;
    if (out_data !== exp_q[0] || rise - first != 7) begin
      n_err++;
      $display("FAIL b2b_total: out_data=%h rise_offset=%0d required %h 7", out_data, rise - first, exp_q[0]);
    end
    void'(exp_q.pop_front());
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_pulse: out_valid=%b in_ready=%b busy=%b required 0 1 0", out_valid, in_ready, busy);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_cancel_and_small;
    logic [15:0] alt[8] = '{16'h4000, 16'hC000, 16'h4000, 16'hC000,
                            16'h4000, 16'hC000, 16'h4000, 16'hC000};
    logic [15:0] three[8] = '{16'h4000, 16'h3C00, 16'h0000, 16'h0000,
                              16'h0000, 16'h0000, 16'h0000, 16'h0000};
    exp_q.push_back(16'h0000);
    send_terms(alt, 8, 0);
    check_total("cancel_zero");
    exp_q.push_back(16'h4200);
    send_terms(three, 1, 0);
    n_cmp++;
    if (add_a !== 16'h4000) begin
      n_err++;
      $display("FAIL first_passthrough: acc=%h required 4000", add_a);
    end
    for (int i = 1; i < 8; i++) three[i-1] = three[i];
    send_terms(three, 7, 0);
    check_total("sum_three");
  endtask

  task automatic test_backpressure;
    logic [15:0] ones[8] = '{default: 16'h3C00};
    exp_q.push_back(16'h4800);
    send_terms(ones, 8, 0);
    in_valid = 1'b1;
    in_data  = 16'h4000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== exp_q[0] || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL hold cycle %0d: ov=%b od=%h ir=%b required 1 %h 0", i, out_valid, out_data, in_ready, exp_q[0]);
      end
    end
    in_valid = 1'b0;
    check_total("hold_total");
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL hold_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_clear;
    logic [15:0] ones[8] = '{default: 16'h3C00};
    send_terms(ones, 3, 0);
    clear = 1'b1; in_valid = 1'b1; in_data = 16'h3C00;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL clear_ready: in_ready=%b required 0", in_ready);
    end
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || add_a !== 16'h0000) begin
      n_err++;
      $display("FAIL clear_acc: busy=%b acc=%h required 0 0000", busy, add_a);
    end
    exp_q.push_back(16'h4800);
    send_terms(ones, 8, 0);
    check_total("after_clear");
    send_terms(ones, 8, 0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || add_a !== 16'h0000) begin
      n_err++;
      $display("FAIL clear_out: ov=%b busy=%b acc=%h required 0 0 0000", out_valid, busy, add_a);
    end
  endtask

  task automatic test_async_reset;
    logic [15:0] ones[8] = '{default: 16'h3C00};
    send_terms(ones, 5, 0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || add_a !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_midsum: busy=%b acc=%h required 0 0000", busy, add_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_terms(ones, 8, 0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_out: ov=%b od=%h ir=%b required 0 0000 1", out_valid, out_data, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(16'h4800);
    send_terms(ones, 8, 0);
    check_total("after_reset");
  endtask

  task automatic test_random_gaps;
    logic [15:0] ones[8] = '{default: 16'h3C00};
    for (int r = 0; r < 3; r++) begin
      exp_q.push_back(16'h4800);
      send_terms(ones, 8, 50);
      check_total("gappy_total");
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_cancel_and_small();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_random_gaps();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

endmodule
